// File: rtl/clique_dump_reader.sv
// Host-side reader for the clique buffer dump stream: captures the {maxsize, n_cliques}
// header, then splits each 32-bit word into two 16-bit vertices tagged with clique ends.
module clique_dump_reader #(
    parameter int SIZE_BITS = 5,
    parameter int VTX_BITS  = 16
) (
    input  logic                 i_clk150,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    output logic                 o_dump,
    input  logic                 i_dump_done,
    input  logic [31:0]          i_data,
    input  logic                 i_data_valid,
    output logic                 o_data_ready,
    output logic [SIZE_BITS-1:0] o_maxsize,
    output logic [15:0]          o_n_cliques,
    output logic                 o_hdr_valid,
    output logic [VTX_BITS-1:0]  o_vtx,
    output logic                 o_vtx_valid,
    input  logic                 i_vtx_ready,
    output logic                 o_vtx_last,
    output logic                 o_done,
    output logic                 o_error,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_VERTS    = 3'd2,
        S_WAITDONE = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    // Handshakes: a word moves when i_data_valid && o_data_ready, a vertex moves when
    // o_vtx_valid && i_vtx_ready; both are sampled on the rising edge of i_clk150.
    state_t               state;
    state_t               state_nxt;
    logic [31:0]          word;
    logic                 word_full;
    logic                 phase;
    logic [SIZE_BITS-1:0] vtx_cnt;
    logic [15:0]          clq_cnt;
    logic [16:0]          clq_cnt_inc;
    logic                 word_acc;
    logic                 vtx_hs;
    logic                 last_vtx;
    logic                 final_hs;
    logic                 truncate;
    logic                 hdr_empty;

    assign o_state     = state;
    assign o_vtx_valid = word_full;
    assign o_vtx       = phase ? word[31:16] : word[15:0];
    assign last_vtx    = (vtx_cnt == o_maxsize - SIZE_BITS'(1));
    assign o_vtx_last  = word_full && last_vtx;
    assign vtx_hs      = word_full && i_vtx_ready;
    assign clq_cnt_inc = {1'b0, clq_cnt} + 17'd1;
    assign final_hs    = vtx_hs && last_vtx && (clq_cnt_inc == {1'b0, o_n_cliques});
    assign word_acc    = i_data_valid && o_data_ready;
    assign hdr_empty   = (i_data[15+SIZE_BITS:16] == '0) || (i_data[15:0] == 16'd0);
    // A word arriving alongside i_dump_done is taken first; truncation waits a cycle.
    assign truncate    = (state == S_VERTS) && i_dump_done && !word_acc && !final_hs;

    always_ff @(posedge i_clk150 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (i_start) state_nxt = S_HDR;
            S_HDR: begin
                if (word_acc) begin
                    state_nxt = hdr_empty ? S_WAITDONE : S_VERTS;
                end else if (i_dump_done) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_VERTS: begin
                if (final_hs) begin
                    state_nxt = S_WAITDONE;
                end else if (truncate) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_WAITDONE: if (i_dump_done) state_nxt = S_RELEASE;
            S_RELEASE:  if (!i_dump_done) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_dump       = 1'b0;
        o_data_ready = 1'b0;
        unique case (state)
            S_HDR, S_WAITDONE: begin
                o_dump       = 1'b1;
                o_data_ready = 1'b1;
            end
            S_VERTS: begin
                o_dump       = 1'b1;
                o_data_ready = !word_full || (vtx_hs && phase);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk150 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_maxsize   <= '0;
            o_n_cliques <= 16'd0;
            o_hdr_valid <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            word        <= 32'd0;
            word_full   <= 1'b0;
            phase       <= 1'b0;
            vtx_cnt     <= '0;
            clq_cnt     <= 16'd0;
        end else begin
            o_hdr_valid <= 1'b0;
            o_done      <= (state == S_RELEASE) && !i_dump_done;
            unique case (state)
                S_IDLE: if (i_start) o_error <= 1'b0;
                S_HDR: begin
                    if (word_acc) begin
                        o_maxsize   <= i_data[15+SIZE_BITS:16];
                        o_n_cliques <= i_data[15:0];
                        o_hdr_valid <= 1'b1;
                        vtx_cnt     <= '0;
                        clq_cnt     <= 16'd0;
                        word_full   <= 1'b0;
                        phase       <= 1'b0;
                    end else if (i_dump_done) begin
                        o_error <= 1'b1;
                    end
                end
                S_VERTS: begin
                    if (vtx_hs) begin
                        if (last_vtx) begin
                            vtx_cnt <= '0;
                            clq_cnt <= clq_cnt + 16'd1;
                        end else begin
                            vtx_cnt <= vtx_cnt + SIZE_BITS'(1);
                        end
                    end
                    if (truncate) begin
                        o_error   <= 1'b1;
                        word_full <= 1'b0;
                    end else if (final_hs) begin
                        // Unused upper half of the last word is discarded; a word taken
                        // on the final handoff is already surplus.
                        word_full <= 1'b0;
                        if (word_acc) o_error <= 1'b1;
                    end else if (word_acc) begin
                        word      <= i_data;
                        word_full <= 1'b1;
                        phase     <= 1'b0;
                    end else if (vtx_hs) begin
                        if (phase) word_full <= 1'b0;
                        else       phase     <= 1'b1;
                    end
                end
                S_WAITDONE: if (word_acc) o_error <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clique_dump_reader.sv
// Bench for clique_dump_reader: a cycle task drives the dump stream and checks emitted
// vertices against an expected queue built from each header and its words.
module tb_clique_dump_reader;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_start;
    logic        o_dump;
    logic        i_dump_done;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [4:0]  o_maxsize;
    logic [15:0] o_n_cliques;
    logic        o_hdr_valid;
    logic [15:0] o_vtx;
    logic        o_vtx_valid;
    logic        i_vtx_ready;
    logic        o_vtx_last;
    logic        o_done;
    logic        o_error;
    logic [2:0]  o_state;

    clique_dump_reader #(.SIZE_BITS(5), .VTX_BITS(16)) dut (
        .i_clk150     (clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .o_dump       (o_dump),
        .i_dump_done  (i_dump_done),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_maxsize    (o_maxsize),
        .o_n_cliques  (o_n_cliques),
        .o_hdr_valid  (o_hdr_valid),
        .o_vtx        (o_vtx),
        .o_vtx_valid  (o_vtx_valid),
        .i_vtx_ready  (i_vtx_ready),
        .o_vtx_last   (o_vtx_last),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    int          hdr_cnt;
    int          done_cnt;
    logic        saw_wait;
    logic        start_drv = 1'b0;
    logic        done_drv  = 1'b0;
    logic        bp_en     = 1'b0;
    logic [3:0]  rdy_pat   = 4'b1001;
    logic        held_valid = 1'b0;
    logic [15:0] held_vtx;
    logic [31:0] src_q[$];
    logic [31:0] words[$];
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, then observe handshakes for the next rise.
    task automatic tick();
        logic [16:0] e;
        @(negedge clk);
        i_start     = start_drv;
        i_dump_done = done_drv;
        if (src_q.size() != 0) begin
            i_data_valid = 1'b1;
            i_data       = src_q[0];
        end else begin
            i_data_valid = 1'b0;
            i_data       = 32'h0;
        end
        i_vtx_ready = bp_en ? rdy_pat[cyc[1:0]] : 1'b1;
        #1;
        if (o_hdr_valid) hdr_cnt++;
        if (o_done) done_cnt++;
        if (o_state == 3'd3) saw_wait = 1'b1;
        if (held_valid && o_vtx_valid) check("vtx_hold", o_vtx, held_vtx);
        if (o_vtx_valid && !i_vtx_ready) check("rdy_stall", o_data_ready, 1'b0);
        if (o_vtx_valid && i_vtx_ready) begin
            if (exp_q.size() == 0) begin
                check("vtx_unexp", o_vtx_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("vtx", {o_vtx_last, o_vtx}, e);
            end
        end
        held_valid = o_vtx_valid && !i_vtx_ready;
        held_vtx   = o_vtx;
        if (i_data_valid && o_data_ready) void'(src_q.pop_front());
        cyc++;
    endtask

    // Queue the header and words, and push the vertices a correct reader would emit.
    task automatic load_dump(input logic [31:0] hdr);
        int ms;
        int total;
        int lim;
        logic [31:0] w;
        src_q.delete();
        exp_q.delete();
        src_q.push_back(hdr);
        foreach (words[k]) src_q.push_back(words[k]);
        ms    = int'(hdr[20:16]);
        total = ms * int'(hdr[15:0]);
        lim   = (total < 2 * words.size()) ? total : 2 * words.size();
        for (int i = 0; i < lim; i++) begin
            w = words[i / 2];
            exp_q.push_back({((i % ms) == ms - 1) ? 1'b1 : 1'b0,
                             (i % 2 == 1) ? w[31:16] : w[15:0]});
        end
        hdr_cnt  = 0;
        done_cnt = 0;
        saw_wait = 1'b0;
    endtask

    task automatic run_dump(input logic [31:0] hdr, input logic exp_err, input logic need_wait);
        int b;
        load_dump(hdr);
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        b = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && b < 500) begin
            tick();
            b++;
        end
        check("feed_in_time", (b < 500), 1'b1);
        tick();
        done_drv = 1'b1;
        b = 0;
        while (o_dump && b < 50) begin
            tick();
            b++;
        end
        check("release_in_time", o_dump, 1'b0);
        done_drv = 1'b0;
        b = 0;
        while (done_cnt == 0 && b < 20) begin
            tick();
            b++;
        end
        tick();
        tick();
        check("done_cnt", done_cnt, 1);
        check("hdr_cnt", hdr_cnt, 1);
        check("error", o_error, exp_err);
        check("exp_left", exp_q.size(), 0);
        check("maxsize", o_maxsize, hdr[20:16]);
        check("n_cliques", o_n_cliques, hdr[15:0]);
        check("idle", o_state, 3'd0);
        if (need_wait) check("saw_wait", saw_wait, 1'b1);
    endtask

    initial begin
        int ms;
        int nc;
        int b;
        i_reset_n    = 1'b0;
        i_start      = 1'b0;
        i_dump_done  = 1'b0;
        i_data       = 32'h0;
        i_data_valid = 1'b0;
        i_vtx_ready  = 1'b0;
        #1;
        check("rst_dump", o_dump, 1'b0);
        check("rst_ready", o_data_ready, 1'b0);
        check("rst_vvalid", o_vtx_valid, 1'b0);
        check("rst_hdrv", o_hdr_valid, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_error", o_error, 1'b0);
        check("rst_maxsize", o_maxsize, 5'd0);
        check("rst_ncl", o_n_cliques, 16'd0);
        check("rst_state", o_state, 3'd0);
        @(negedge clk);
        @(negedge clk);
        i_reset_n = 1'b1;

        words = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
        run_dump(32'h0004_0002, 1'b0, 1'b1);

        words = '{32'h0002_0001, 32'hBEEF_0003};
        run_dump(32'h0003_0001, 1'b0, 1'b1);

        bp_en = 1'b1;
        words = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
        run_dump(32'h0004_0002, 1'b0, 1'b1);
        bp_en = 1'b0;

        words = '{32'h0002_0001, 32'h0004_0003};
        run_dump(32'h0004_0002, 1'b1, 1'b0);

        words.delete();
        run_dump(32'h0005_0000, 1'b0, 1'b1);

        words = '{32'h0002_0001, 32'h0004_0003};
        run_dump(32'h0002_0001, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            ms = $urandom_range(1, 4);
            nc = $urandom_range(1, 3);
            bp_en = r[0];
            words.delete();
            for (int k = 0; k < (ms * nc + 1) / 2; k++) words.push_back($urandom);
            run_dump({11'($urandom_range(0, 2047)), 5'(ms), 16'(nc)}, 1'b0, 1'b1);
        end
        bp_en = 1'b0;

        words = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
        load_dump(32'h0004_0002);
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        b = 0;
        while (!(o_state == 3'd2 && o_vtx_valid) && b < 50) begin
            tick();
            b++;
        end
        check("mid_verts", o_state, 3'd2);
        i_reset_n = 1'b0;
        #1;
        check("mid_dump", o_dump, 1'b0);
        check("mid_vvalid", o_vtx_valid, 1'b0);
        check("mid_ready", o_data_ready, 1'b0);
        src_q.delete();
        exp_q.delete();
        held_valid = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b1;
        run_dump(32'h0004_0002, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/clique_dump_reader.md
Name: clique_dump_reader

Overview:
- Host-side consumer of the clique buffer's 32-bit dump stream.
- On command, it raises the dump request and captures the header word {maxsize, n_cliques}.
- It then unpacks each 32-bit word into two 16-bit vertices and emits them one per handshake, tagged with clique boundaries.
- It checks vertex count against the header, flags truncated or overlong dumps, and completes the request/done handshake with the buffer.

Parameters:
SIZE_BITS, 5, width of the clique-size field (matches MAX_CLIQUESIZEBITS); header bits [15+SIZE_BITS:16] used, the rest ignored.
VTX_BITS, 16, vertex width; two vertices per 32-bit word; fixed 16 in this revision.

Ports:
i_clk150  in  1  dump-side clock; all logic on the rising edge.
i_reset_n  in  1  asynchronous, active-low reset.
i_start  in  1  one-cycle pulse to begin a dump; ignored unless in S_IDLE.
o_dump  out  1  dump request to the clique buffer.
i_dump_done  in  1  buffer has finished sending.
i_data  in  32  dump word.
i_data_valid  in  1  dump word valid.
o_data_ready  out  1  dump word accepted when valid && ready.
o_maxsize  out  SIZE_BITS  captured clique size.
o_n_cliques  out  16  captured clique count.
o_hdr_valid  out  1  one-cycle pulse when the header is captured.
o_vtx  out  16  vertex.
o_vtx_valid  out  1  vertex valid.
i_vtx_ready  in  1  downstream accepts the vertex.
o_vtx_last  out  1  vertex is the last of its clique (qualified by o_vtx_valid).
o_done  out  1  one-cycle pulse when the dump transaction completes.
o_error  out  1  sticky; cleared on the next accepted i_start.

Behaviour:
- Reset values:
  - State S_IDLE.
  - All outputs 0.
  - Word register empty; counters 0.
- States:
  - S_IDLE: o_dump=0, o_data_ready=0. On i_start go to S_HDR and clear o_error.
  - S_HDR: o_dump=1, o_data_ready=1. On the first accepted word:
    - o_maxsize = i_data[15+SIZE_BITS:16], o_n_cliques = i_data[15:0]; o_hdr_valid pulses the next cycle.
    - Vertex counter = 0, clique counter = 0.
    - If n_cliques==0 or maxsize==0, go to S_WAITDONE; else go to S_VERTS.
    - If i_dump_done is seen before the header arrives, set o_error and go to S_RELEASE.
  - S_VERTS: o_dump=1.
    - o_data_ready = !word_full || (o_vtx_valid && i_vtx_ready && phase==1).
    - An accepted word loads the word register with phase=0.
    - o_vtx = phase ? word[31:16] : word[15:0]; o_vtx_valid = word_full.
    - Latency: word accepted in cycle N gives its low vertex on o_vtx in cycle N+1.
    - On each vertex handshake: the vertex-in-clique counter increments. When it equals maxsize-1, o_vtx_last=1 for that vertex, the counter wraps to 0, and the clique counter increments.
    - When the final vertex is handed off (clique counter reaches n_cliques), the word register is emptied even if phase==0. The upper half of an odd-count final word is discarded.
    - The final handoff moves the block to S_WAITDONE.
    - Maximum throughput: 2 vertices per 2 cycles, with back-to-back words when downstream is always ready.
  - S_WAITDONE: o_dump=1, o_data_ready=1.
    - Any accepted word here is surplus: it is dropped and sets o_error.
    - On i_dump_done go to S_RELEASE.
  - S_RELEASE: o_dump=0, o_data_ready=0. When i_dump_done==0, pulse o_done and go to S_IDLE.
- Truncation: i_dump_done=1 in S_VERTS while vertices are still outstanding:
  - Set o_error.
  - Drop any partial word register (o_vtx_valid falls the next cycle).
  - Go to S_RELEASE.
- Simultaneous events:
  - A word valid in the same cycle as i_dump_done in S_VERTS: the word is accepted and processed first; the truncation check applies after the final vertex is counted.
  - i_start outside S_IDLE is ignored.
- Arithmetic and widths:
  - Vertex-in-clique counter is SIZE_BITS wide.
  - Clique counter is 16 bits; compared against o_n_cliques with no wrap (n_cliques max 65535).
- o_vtx holds stable while o_vtx_valid && !i_vtx_ready.
- Reset mid-operation: asynchronous return to the reset values above, with o_dump dropping immediately. The buffer then sees o_dump low and returns to its idle state.

Test Plan:
- Basic even dump:
  - Stimulus: header 0x0004_0002, then words 0x0002_0001, 0x0004_0003, 0x0006_0005, 0x0008_0007, i_vtx_ready=1.
  - Required: vertices 1..8 in order; o_vtx_last on vertices 4 and 8; o_hdr_valid once; o_done after i_dump_done high then low; o_error=0.
- Odd total:
  - Stimulus: header 0x0003_0001, words 0x0002_0001, 0xBEEF_0003.
  - Required: vertices 1,2,3 with last on 3; 0xBEEF never output; S_WAITDONE entered; o_error=0.
- Empty buffer:
  - Stimulus: header 0x0005_0000, then i_dump_done.
  - Required: no o_vtx_valid; o_done pulse; o_error=0.
- Backpressure:
  - Stimulus: the basic even dump with i_vtx_ready toggling 1,0,0,1.
  - Required: o_vtx stable while stalled; o_data_ready low while phase==0 is pending; sequence is identical to the basic even dump.
- Truncation and overrun:
  - Truncation: header 0x0004_0002, two words, then i_dump_done → o_error=1, o_done pulse, 4 vertices emitted.
  - Overrun: header 0x0002_0001 followed by two words → second word dropped, o_error=1.
- Reset mid-dump:
  - Stimulus: assert i_reset_n=0 during S_VERTS.
  - Required: o_dump, o_vtx_valid and o_data_ready are 0 in the same cycle; a following i_start yields a clean dump.
